// File: rtl/sdram_port_arbiter_pkg.sv
// rtl/sdram_port_arbiter_pkg.sv - shared port indices and defaults for the SDRAM port arbiter
package sdram_port_arbiter_pkg;

  localparam int NUM_PORTS = 4;
  localparam int AW_DEF    = 25;
  localparam int DW_DEF    = 128;

  localparam logic [1:0] PORT_CAM    = 2'd0;
  localparam logic [1:0] PORT_VGA    = 2'd1;
  localparam logic [1:0] PORT_HDR_RD = 2'd2;
  localparam logic [1:0] PORT_HDR_WR = 2'd3;

  // Round-robin successor among the three non-camera ports.
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    case (p)
      PORT_VGA:    rr_next = PORT_HDR_RD;
      PORT_HDR_RD: rr_next = PORT_HDR_WR;
      default:     rr_next = PORT_VGA;
    endcase
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - requester and SDRAM controller signals of the port arbiter
interface sdram_port_arbiter_if
  import sdram_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          cam_wr_req;
  logic [AW-1:0] cam_wr_addr;
  logic [DW-1:0] cam_wr_data;
  logic          vga_rd_req;
  logic [AW-1:0] vga_rd_addr;
  logic          hdr_rd_req;
  logic [AW-1:0] hdr_rd_addr;
  logic          hdr_wr_req;
  logic [AW-1:0] hdr_wr_addr;
  logic [DW-1:0] hdr_wr_data;
  logic [3:0]    port_ack;
  logic          vga_rd_valid;
  logic          hdr_rd_valid;
  logic [DW-1:0] rd_data;
  logic          ram_cmd_valid;
  logic          ram_cmd_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_cmd_ready;
  logic          ram_rd_valid;
  logic [DW-1:0] ram_rd_data;
  logic [3:0]    err_overflow;
  logic          err_spurious;

  modport slave (
    input  cam_wr_req, cam_wr_addr, cam_wr_data, vga_rd_req, vga_rd_addr,
           hdr_rd_req, hdr_rd_addr, hdr_wr_req, hdr_wr_addr, hdr_wr_data,
           ram_cmd_ready, ram_rd_valid, ram_rd_data,
    output port_ack, vga_rd_valid, hdr_rd_valid, rd_data,
           ram_cmd_valid, ram_cmd_we, ram_addr, ram_wdata, err_overflow, err_spurious
  );

  modport master (
    output cam_wr_req, cam_wr_addr, cam_wr_data, vga_rd_req, vga_rd_addr,
           hdr_rd_req, hdr_rd_addr, hdr_wr_req, hdr_wr_addr, hdr_wr_data,
           ram_cmd_ready, ram_rd_valid, ram_rd_data,
    input  port_ack, vga_rd_valid, hdr_rd_valid, rd_data,
           ram_cmd_valid, ram_cmd_we, ram_addr, ram_wdata, err_overflow, err_spurious
  );

endinterface

// File: rtl/sdram_tag_fifo.sv
// rtl/sdram_tag_fifo.sv - in-order tag FIFO recording which port owns each outstanding read
module sdram_tag_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + PW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - four-port SDRAM command arbiter: camera priority, round-robin for the rest
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int AW              = AW_DEF,
  parameter int DW              = DW_DEF,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic               clk,
  input logic               rst_n,
  sdram_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [NUM_PORTS-1:0] req;
  logic [AW-1:0]        req_addr [NUM_PORTS];

  logic [NUM_PORTS-1:0] slot_vld_q, slot_vld_d;
  logic [AW-1:0]        slot_addr_q [NUM_PORTS];
  logic [AW-1:0]        slot_addr_d [NUM_PORTS];
  logic [DW-1:0]        cam_data_q, cam_data_d;
  logic [DW-1:0]        hdrw_data_q, hdrw_data_d;
  logic [NUM_PORTS-1:0] load, freed, elig;

  logic                 cmd_valid_q, cmd_valid_d;
  logic                 cmd_we_q, cmd_we_d;
  logic [AW-1:0]        cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]        cmd_wdata_q, cmd_wdata_d;
  logic [1:0]           cmd_port_q, cmd_port_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;

  logic [3:0]           port_ack_q, port_ack_d;
  logic                 vga_rd_valid_q, vga_rd_valid_d;
  logic                 hdr_rd_valid_q, hdr_rd_valid_d;
  logic [DW-1:0]        rd_data_q, rd_data_d;
  logic [3:0]           err_ovf_q, err_ovf_d;
  logic                 err_spur_q, err_spur_d;

  logic                 accept, stage_free, tag_ok;
  logic                 gnt_vld;
  logic [1:0]           gnt_port, cand;
  logic                 tag_push, tag_pop, tag_rd, tag_full, tag_empty;
  logic [CW-1:0]        tag_count;

  assign req         = {bus.hdr_wr_req, bus.hdr_rd_req, bus.vga_rd_req, bus.cam_wr_req};
  assign req_addr[0] = bus.cam_wr_addr;
  assign req_addr[1] = bus.vga_rd_addr;
  assign req_addr[2] = bus.hdr_rd_addr;
  assign req_addr[3] = bus.hdr_wr_addr;

  assign accept     = cmd_valid_q && bus.ram_cmd_ready;
  assign stage_free = !cmd_valid_q || bus.ram_cmd_ready;

  // Tag 1 marks an HDR read, 0 a VGA read.
  assign tag_push = accept && !cmd_we_q;
  assign tag_pop  = bus.ram_rd_valid && !tag_empty;
  // A read may only be staged if its tag will fit, including the tag pushed on this edge.
  assign tag_ok   = !(tag_full || (tag_push && (tag_count == CW'(MAX_OUTSTANDING - 1))));

  sdram_tag_fifo #(.W(1), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_push),
    .push_data (cmd_port_q == PORT_HDR_RD),
    .pop       (tag_pop),
    .rd_data   (tag_rd),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  // A slot stays full while its command sits in the output stage; it frees on acceptance.
  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    err_ovf_d   = err_ovf_q;
    load        = '0;
    freed       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      freed[i] = accept && (cmd_port_q == 2'(i));
      if (freed[i]) slot_vld_d[i] = 1'b0;
      if (req[i]) begin
        if (slot_vld_q[i] && !freed[i]) begin
          err_ovf_d[i] = 1'b1;
        end else begin
          load[i]        = 1'b1;
          slot_vld_d[i]  = 1'b1;
          slot_addr_d[i] = req_addr[i];
        end
      end
    end
    cam_data_d  = load[PORT_CAM]    ? bus.cam_wr_data : cam_data_q;
    hdrw_data_d = load[PORT_HDR_WR] ? bus.hdr_wr_data : hdrw_data_q;
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = slot_vld_q[i] && !(cmd_valid_q && (cmd_port_q == 2'(i)));
      if ((2'(i) == PORT_VGA) || (2'(i) == PORT_HDR_RD)) elig[i] = elig[i] && tag_ok;
    end
  end

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = PORT_CAM;
    cand     = rr_ptr_q;
    if (elig[PORT_CAM]) begin
      gnt_vld = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!gnt_vld && elig[cand]) begin
          gnt_vld  = 1'b1;
          gnt_port = cand;
        end
        cand = rr_next(cand);
      end
    end
  end

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_port_d  = cmd_port_q;
    rr_ptr_d    = rr_ptr_q;
    if (stage_free) begin
      cmd_valid_d = gnt_vld;
      if (gnt_vld) begin
        cmd_we_d   = (gnt_port == PORT_CAM) || (gnt_port == PORT_HDR_WR);
        cmd_addr_d = slot_addr_q[gnt_port];
        cmd_port_d = gnt_port;
        if (gnt_port == PORT_CAM)         cmd_wdata_d = cam_data_q;
        else if (gnt_port == PORT_HDR_WR) cmd_wdata_d = hdrw_data_q;
        else                              cmd_wdata_d = '0;
        if (gnt_port != PORT_CAM) rr_ptr_d = rr_next(gnt_port);
      end
    end
  end

  always_comb begin
    port_ack_d     = accept ? (4'b0001 << cmd_port_q) : 4'b0000;
    vga_rd_valid_d = tag_pop && !tag_rd;
    hdr_rd_valid_d = tag_pop && tag_rd;
    rd_data_d      = tag_pop ? bus.ram_rd_data : rd_data_q;
    err_spur_d     = err_spur_q || (bus.ram_rd_valid && tag_empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) slot_addr_q[i] <= '0;
      cam_data_q     <= '0;
      hdrw_data_q    <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_we_q       <= 1'b0;
      cmd_addr_q     <= '0;
      cmd_wdata_q    <= '0;
      cmd_port_q     <= PORT_CAM;
      rr_ptr_q       <= PORT_VGA;
      port_ack_q     <= '0;
      vga_rd_valid_q <= 1'b0;
      hdr_rd_valid_q <= 1'b0;
      rd_data_q      <= '0;
      err_ovf_q      <= '0;
      err_spur_q     <= 1'b0;
    end else begin
      slot_vld_q     <= slot_vld_d;
      slot_addr_q    <= slot_addr_d;
      cam_data_q     <= cam_data_d;
      hdrw_data_q    <= hdrw_data_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_we_q       <= cmd_we_d;
      cmd_addr_q     <= cmd_addr_d;
      cmd_wdata_q    <= cmd_wdata_d;
      cmd_port_q     <= cmd_port_d;
      rr_ptr_q       <= rr_ptr_d;
      port_ack_q     <= port_ack_d;
      vga_rd_valid_q <= vga_rd_valid_d;
      hdr_rd_valid_q <= hdr_rd_valid_d;
      rd_data_q      <= rd_data_d;
      err_ovf_q      <= err_ovf_d;
      err_spur_q     <= err_spur_d;
    end
  end

  assign bus.port_ack      = port_ack_q;
  assign bus.vga_rd_valid  = vga_rd_valid_q;
  assign bus.hdr_rd_valid  = hdr_rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.ram_cmd_valid = cmd_valid_q;
  assign bus.ram_cmd_we    = cmd_we_q;
  assign bus.ram_addr      = cmd_addr_q;
  assign bus.ram_wdata     = cmd_wdata_q;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.err_spurious  = err_spur_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed scoreboard bench for the SDRAM port arbiter
module tb_sdram_port_arbiter;
  import sdram_port_arbiter_pkg::*;

  localparam int AW = 25;
  localparam int DW = 128;

  typedef struct {
    logic [1:0]    port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  sdram_port_arbiter #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  cmd_t          exp_cmd_q [$];
  logic [1:0]    tag_q [$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [3:0]    exp_ack = '0;
  logic          exp_vga = 1'b0;
  logic          exp_hdr = 1'b0;
  logic [DW-1:0] exp_rdata = '0;
  logic [3:0]    exp_ovf = '0;
  logic          exp_spur = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_cmd(input logic [1:0] port, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cmd_t c;
    c.port = port; c.we = we; c.addr = addr; c.data = data;
    exp_cmd_q.push_back(c);
  endtask

  // One clock: check registered outputs against the model, advance the model across the edge.
  task automatic cyc();
    cmd_t          c;
    logic [1:0]    t;
    logic [3:0]    nack;
    logic          nv, nh, nspur;
    logic [DW-1:0] nd;
    chk("port_ack", bus.port_ack, exp_ack);
    chk("vga_rd_valid", bus.vga_rd_valid, exp_vga);
    chk("hdr_rd_valid", bus.hdr_rd_valid, exp_hdr);
    if (exp_vga || exp_hdr) chk("rd_data", bus.rd_data, exp_rdata);
    chk("err_overflow", bus.err_overflow, exp_ovf);
    chk("err_spurious", bus.err_spurious, exp_spur);
    nack = '0; nv = 1'b0; nh = 1'b0; nd = exp_rdata; nspur = exp_spur;
    if (rst_n) begin
      if (bus.ram_rd_valid) begin
        if (tag_q.size() > 0) begin
          t  = tag_q.pop_front();
          nv = (t == PORT_VGA);
          nh = (t == PORT_HDR_RD);
          nd = bus.ram_rd_data;
        end else begin
          nspur = 1'b1;
        end
      end
      if (bus.ram_cmd_valid && bus.ram_cmd_ready) begin
        n_cmp++;
        assert (exp_cmd_q.size() > 0) else begin
          n_err++;
          $error("FAIL cmd_unexpected observed addr=%0h expected no command", bus.ram_addr);
        end
        if (exp_cmd_q.size() > 0) begin
          c = exp_cmd_q.pop_front();
          chk("cmd_we", bus.ram_cmd_we, c.we);
          chk("cmd_addr", bus.ram_addr, c.addr);
          if (c.we) chk("cmd_wdata", bus.ram_wdata, c.data);
          nack = 4'b0001 << c.port;
          if (!c.we) tag_q.push_back(c.port);
        end
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      nack = '0; nv = 1'b0; nh = 1'b0; nd = '0; nspur = 1'b0;
      exp_ovf = '0;
      tag_q.delete();
      exp_cmd_q.delete();
    end
    exp_ack = nack; exp_vga = nv; exp_hdr = nh; exp_rdata = nd; exp_spur = nspur;
    #1;
    bus.cam_wr_req = 1'b0; bus.vga_rd_req = 1'b0; bus.hdr_rd_req = 1'b0; bus.hdr_wr_req = 1'b0;
    bus.ram_rd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    repeat (n) cyc();
  endtask

  task automatic ret(input logic [DW-1:0] d);
    bus.ram_rd_valid = 1'b1;
    bus.ram_rd_data  = d;
    cyc();
  endtask

  initial begin
    bus.cam_wr_req = 1'b0; bus.cam_wr_addr = '0; bus.cam_wr_data = '0;
    bus.vga_rd_req = 1'b0; bus.vga_rd_addr = '0;
    bus.hdr_rd_req = 1'b0; bus.hdr_rd_addr = '0;
    bus.hdr_wr_req = 1'b0; bus.hdr_wr_addr = '0; bus.hdr_wr_data = '0;
    bus.ram_cmd_ready = 1'b0; bus.ram_rd_valid = 1'b0; bus.ram_rd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk("rst_cmd_valid", bus.ram_cmd_valid, 0);
    chk("rst_port_ack", bus.port_ack, 0);
    chk("rst_rd_valid", {bus.vga_rd_valid, bus.hdr_rd_valid}, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_errs", {bus.err_overflow, bus.err_spurious}, 0);

    // Single VGA read and its return.
    bus.ram_cmd_ready = 1'b1;
    bus.vga_rd_req = 1'b1; bus.vga_rd_addr = 25'h25800;
    push_cmd(PORT_VGA, 1'b0, 25'h25800, '0);
    cyc();
    chk("t1_e0_valid", bus.ram_cmd_valid, 0);
    cyc();
    chk("t1_valid", bus.ram_cmd_valid, 1);
    chk("t1_we", bus.ram_cmd_we, 0);
    chk("t1_addr", bus.ram_addr, 25'h25800);
    cyc();
    chk("t1_ack", bus.port_ack, 4'b0010);
    drain(2);
    ret({16{8'hA5}});
    chk("t1_vga_valid", bus.vga_rd_valid, 1);
    chk("t1_hdr_valid", bus.hdr_rd_valid, 0);
    chk("t1_rd_data", bus.rd_data, {16{8'hA5}});
    drain(2);

    // Camera write beats a simultaneous HDR read; they issue back to back.
    bus.cam_wr_req = 1'b1; bus.cam_wr_addr = 25'h1000; bus.cam_wr_data = {4{32'hCAFE0001}};
    bus.hdr_rd_req = 1'b1; bus.hdr_rd_addr = 25'h2000;
    push_cmd(PORT_CAM, 1'b1, 25'h1000, {4{32'hCAFE0001}});
    push_cmd(PORT_HDR_RD, 1'b0, 25'h2000, '0);
    cyc();
    cyc();
    chk("t2_cam_we", bus.ram_cmd_we, 1);
    chk("t2_cam_addr", bus.ram_addr, 25'h1000);
    cyc();
    chk("t2_hdr_valid", bus.ram_cmd_valid, 1);
    chk("t2_hdr_addr", bus.ram_addr, 25'h2000);
    drain(2);
    ret({8{16'h1234}});
    chk("t2_hdr_rd_valid", bus.hdr_rd_valid, 1);
    drain(2);

    // Single HDR write leaves the round-robin pointer at VGA.
    bus.hdr_wr_req = 1'b1; bus.hdr_wr_addr = 25'h3000; bus.hdr_wr_data = {4{32'h0BADF00D}};
    push_cmd(PORT_HDR_WR, 1'b1, 25'h3000, {4{32'h0BADF00D}});
    drain(4);

    // Three-way contention through a 5-cycle stall, then two RR rounds.
    for (int r = 0; r < 2; r++) begin
      bus.ram_cmd_ready = (r == 1);
      bus.vga_rd_req = 1'b1; bus.vga_rd_addr = 25'h100 + 25'(r * 16);
      bus.hdr_rd_req = 1'b1; bus.hdr_rd_addr = 25'h200 + 25'(r * 16);
      bus.hdr_wr_req = 1'b1; bus.hdr_wr_addr = 25'h300 + 25'(r * 16); bus.hdr_wr_data = {4{32'hD3D3_0000 + r}};
      push_cmd(PORT_VGA, 1'b0, 25'h100 + 25'(r * 16), '0);
      push_cmd(PORT_HDR_RD, 1'b0, 25'h200 + 25'(r * 16), '0);
      push_cmd(PORT_HDR_WR, 1'b1, 25'h300 + 25'(r * 16), {4{32'hD3D3_0000 + r}});
      cyc();
      if (r == 0) begin
        cyc();
        for (int s = 0; s < 5; s++) begin
          chk("t3_stall_valid", bus.ram_cmd_valid, 1);
          chk("t3_stall_we", bus.ram_cmd_we, 0);
          chk("t3_stall_addr", bus.ram_addr, 25'h100);
          cyc();
        end
        bus.ram_cmd_ready = 1'b1;
      end
      drain(5);
      ret({4{32'h11110000 + r}});
      ret({4{32'h22220000 + r}});
      drain(2);
    end

    // Fill the tag FIFO; a fifth read waits while a write still goes out.
    for (int r = 0; r < 2; r++) begin
      bus.vga_rd_req = 1'b1; bus.vga_rd_addr = 25'h400 + 25'(r * 16);
      bus.hdr_rd_req = 1'b1; bus.hdr_rd_addr = 25'h500 + 25'(r * 16);
      push_cmd(PORT_VGA, 1'b0, 25'h400 + 25'(r * 16), '0);
      push_cmd(PORT_HDR_RD, 1'b0, 25'h500 + 25'(r * 16), '0);
      drain(5);
    end
    bus.vga_rd_req = 1'b1; bus.vga_rd_addr = 25'h420;
    bus.hdr_wr_req = 1'b1; bus.hdr_wr_addr = 25'h600; bus.hdr_wr_data = {4{32'h600D600D}};
    push_cmd(PORT_HDR_WR, 1'b1, 25'h600, {4{32'h600D600D}});
    push_cmd(PORT_VGA, 1'b0, 25'h420, '0);
    drain(3);
    for (int s = 0; s < 4; s++) begin
      chk("t4_blocked", bus.ram_cmd_valid, 0);
      cyc();
    end
    ret({4{32'h44440000}});
    drain(3);
    n_cmp++;
    assert (exp_cmd_q.size() == 0) else begin
      n_err++;
      $error("FAIL t4_fifth_read observed pending=%0d expected 0", exp_cmd_q.size());
    end
    for (int i = 0; i < 4; i++) ret({4{32'h55550000 + i}});
    drain(2);

    // Overflow on a second HDR read while the first is stalled.
    bus.ram_cmd_ready = 1'b0;
    bus.hdr_rd_req = 1'b1; bus.hdr_rd_addr = 25'h700;
    push_cmd(PORT_HDR_RD, 1'b0, 25'h700, '0);
    cyc();
    bus.hdr_rd_req = 1'b1; bus.hdr_rd_addr = 25'h701;
    cyc();
    exp_ovf = 4'b0100;
    chk("t5_ovf", bus.err_overflow, 4'b0100);
    bus.ram_cmd_ready = 1'b1;
    drain(4);
    ret({4{32'h77770000}});
    drain(2);
    chk("t5_ovf_sticky", bus.err_overflow, 4'b0100);

    // Spurious return, then reset with two reads in flight.
    ret({4{32'hDEAD0000}});
    chk("t6_spur", bus.err_spurious, 1);
    chk("t6_spur_novalid", {bus.vga_rd_valid, bus.hdr_rd_valid}, 0);
    bus.vga_rd_req = 1'b1; bus.vga_rd_addr = 25'h800;
    bus.hdr_rd_req = 1'b1; bus.hdr_rd_addr = 25'h900;
    push_cmd(PORT_VGA, 1'b0, 25'h800, '0);
    push_cmd(PORT_HDR_RD, 1'b0, 25'h900, '0);
    drain(5);
    rst_n = 1'b0;
    drain(2);
    rst_n = 1'b1;
    chk("t6_rst_valid", bus.ram_cmd_valid, 0);
    chk("t6_rst_ack", bus.port_ack, 0);
    chk("t6_rst_errs", {bus.err_overflow, bus.err_spurious}, 0);
    chk("t6_rst_rd_data", bus.rd_data, 0);
    ret({4{32'hBEEF0000}});
    chk("t6_post_rst_spur", bus.err_spurious, 1);
    chk("t6_post_rst_novalid", {bus.vga_rd_valid, bus.hdr_rd_valid}, 0);
    drain(2);

    n_cmp++;
    assert (exp_cmd_q.size() == 0 && tag_q.size() == 0) else begin
      n_err++;
      $error("FAIL end_drain observed cmds=%0d tags=%0d expected 0", exp_cmd_q.size(), tag_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Shares the single SDRAM command interface (25-bit word address, 128-bit data) among four requesters: camera write, VGA read, HDR read and HDR write. The camera port has strict priority because it is real-time. The other three ports are served round-robin. Read data is routed back to the port that issued the read through an in-order tag FIFO. The block sits between the capture/HDR/display blocks and the SDRAM controller.

Parameters:
AW, 25, address width
DW, 128, data width
MAX_OUTSTANDING, 4, read tag FIFO depth (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cam_wr_req  in  1  pulse: camera write request
cam_wr_addr  in  AW  camera write address
cam_wr_data  in  DW  camera write data
vga_rd_req  in  1  pulse: VGA read request
vga_rd_addr  in  AW  VGA read address
hdr_rd_req  in  1  pulse: HDR read request
hdr_rd_addr  in  AW  HDR read address
hdr_wr_req  in  1  pulse: HDR write request
hdr_wr_addr  in  AW  HDR write address
hdr_wr_data  in  DW  HDR write data
port_ack  out  4  one-cycle pulse per port when its command is accepted; bit 0 cam, 1 vga, 2 hdr_rd, 3 hdr_wr
vga_rd_valid  out  1  read data for VGA on rd_data
hdr_rd_valid  out  1  read data for HDR on rd_data
rd_data  out  DW  registered read return data
ram_cmd_valid  out  1  command valid to SDRAM controller
ram_cmd_we  out  1  1 = write, 0 = read
ram_addr  out  AW  command address
ram_wdata  out  DW  write data
ram_cmd_ready  in  1  controller accepts the command this cycle
ram_rd_valid  in  1  read data return strobe (in issue order)
ram_rd_data  in  DW  read data
err_overflow  out  4  sticky per port: request arrived while that port already had a request pending
err_spurious  out  1  sticky: ram_rd_valid arrived with the tag FIFO empty

Behaviour:
- Reset: all outputs 0, pending slots cleared, tag FIFO emptied, round-robin pointer set to vga. Reset mid-operation discards pending and in-flight tags. Returns arriving after reset are counted as spurious.
- Pending slots: each port has a 1-deep slot holding address (and data for writes). A req pulse at edge E loads the slot.
  - If the slot is still full at E and not being accepted on E: the new request is dropped and the port's err_overflow bit is set.
  - If the slot is accepted on the same edge as a new req: the new request is loaded and no error is flagged.
- Output stage: ram_cmd_valid/we/addr/wdata are registered.
  - The stage is loaded when empty, or when it is accepted (ram_cmd_valid && ram_cmd_ready) on that edge.
  - While ram_cmd_valid is high and ram_cmd_ready is low, all command outputs stay stable.
- Arbitration (at load time):
  - Camera pending wins unconditionally.
  - Otherwise grant the first pending port among {vga, hdr_rd, hdr_wr}, starting from the RR pointer. The pointer moves to the port after the winner.
  - A read is eligible only if the tag FIFO is not full, counting the tag being pushed this edge.
- Latency: req pulse at E0, then ram_cmd_valid high after E1 when uncontended and the stage is free. A back-to-back stream is possible: one command per cycle while ram_cmd_ready stays high.
- port_ack[i]: a 1-cycle pulse in the cycle after the edge where port i's command is accepted. The slot is freed on that acceptance edge.
- Tag FIFO: on acceptance of a read, push the port id (vga or hdr). On ram_rd_valid, pop.
  - Next cycle: rd_data <= ram_rd_data and exactly one of vga_rd_valid / hdr_rd_valid is high.
  - Simultaneous push and pop is legal and keeps the count unchanged.
  - Pop while empty: no valid is asserted and err_spurious is set.
- Writes never use tags. Read/write ordering between ports is the accept order at the controller.
- err flags clear only on reset.

Decomposition:
- Shared package: port index constants (PORT_CAM=0, PORT_VGA=1, PORT_HDR_RD=2, PORT_HDR_WR=3), NUM_PORTS=4, AW/DW defaults.
- One sub-module: sdram_tag_fifo (synchronous FIFO, width 1, depth MAX_OUTSTANDING) with full, empty and count outputs.

Test Plan:
- Single vga_rd_req with addr 0x25800 and ram_cmd_ready=1: ram_cmd_valid=1, we=0, addr=0x25800 one cycle after the request; port_ack=4'b0010. Return ram_rd_data=0xA5..A5 three cycles later → next cycle vga_rd_valid=1, rd_data=0xA5..A5, hdr_rd_valid=0.
- cam_wr_req and hdr_rd_req in the same cycle: camera write (we=1) issues first, HDR read second, on consecutive cycles.
- vga, hdr_rd and hdr_wr all held pending while ram_cmd_ready=0 for 5 cycles, then ready=1: command outputs stay stable during stall; afterwards the order is RR vga → hdr_rd → hdr_wr, and the next round starts at vga.
- Issue 4 reads with no returns (MAX_OUTSTANDING=4): a 5th read stays pending while a hdr_wr_req is still issued. After one ram_rd_valid, the 5th read issues.
- Second hdr_rd_req while the first is pending and ram_cmd_ready=0: err_overflow=4'b0100 sticky; only one read is issued.
- ram_rd_valid with no outstanding reads → err_spurious=1, no rd_valid. Assert rst_n=0 with 2 reads outstanding → all outputs 0 and the FIFO empties.
